idli_uart_rx_m: RTL

// - UART receiver that consumes the core's serial output (o_top_uart_tx) inside the bench/SoC.
// - Deserialises 8N1 frames into bytes and hands them on over a valid/ready interface.
// - Sits directly downstream of idli_top_m. Runs in the core's gck domain, so no baud clock exists.
// - The bench reads decoded console output from this block instead of bit-banging the line.
//

---
 rtl/idli_pkg.sv | 14 +
 rtl/idli_uart_rx_fifo_m.sv | 46 ++++
 rtl/idli_uart_rx_m.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/idli_pkg.sv
// Shared types for the idli UART receive path: byte type and receiver FSM states.
package idli_pkg;

   typedef logic [7:0] uart_byte_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } urx_state_t;

endpackage

// File: rtl/idli_uart_rx_fifo_m.sv
// First-word-fall-through byte FIFO for the UART receiver (used with IDLI_UART_RX_FIFO_EN).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module idli_uart_rx_fifo_m
   import idli_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       i_gck,
   input  logic       i_rst_n,
   input  logic       i_push,
   input  uart_byte_t i_data,
   input  logic       i_pop,
   output uart_byte_t o_data,
   output logic       o_full,
   output logic       o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  r_wr;
   logic [AW:0]  r_rd;
   uart_byte_t   r_mem [DEPTH];
   logic         w_do_pop;
   logic         w_do_push;

   assign o_empty   = (r_wr == r_rd);
   assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_data    = r_mem[r_rd[AW-1:0]];

   always_ff @(posedge i_gck or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr <= '0;
         r_rd <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr[AW-1:0]] <= i_data;
            r_wr                <= r_wr + 1'b1;
         end
         if (w_do_pop) r_rd <= r_rd + 1'b1;
      end
   end

endmodule

// File: rtl/idli_uart_rx_m.sv
// 8N1 UART receiver in the core clock domain with valid/ready output.
// Define IDLI_UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO instead of a single holding register.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | half bit-time wait, then confirm start bit
// DATA  | sample 8 data bits, LSB first
// STOP  | sample stop bit; push byte or flag framing error
// BREAK | stop bit was low; wait for line to return high
module idli_uart_rx_m
   import idli_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       i_urx_gck,
   input  logic       i_urx_rst_n,
   input  logic       i_urx_rx,
   output logic [7:0] o_urx_data,
   output logic       o_urx_vld,
   input  logic       i_urx_rdy,
   output logic       o_urx_frame_err,
   output logic       o_urx_overflow
);

   localparam int              CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]   CNT_FULL = CW'(CLKS_PER_BIT - 1);

   if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT % 2 != 0) || (FIFO_DEPTH < 2)) begin : g_param_err
      $error("idli_uart_rx_m: CLKS_PER_BIT must be even and >= 4, FIFO_DEPTH >= 2");
   end

   logic [1:0]    r_sync;
   logic          w_rx_s;
   urx_state_t    r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]    r_bit, w_bit_nxt;
   uart_byte_t    r_sr, w_sr_nxt;
   logic          w_cnt_zero;
   logic          w_push;
   logic          w_ferr;
   logic          w_pop;
   logic          w_full;
   logic          r_ferr;
   logic          r_ovf;

   assign w_rx_s     = r_sync[1];
   assign w_cnt_zero = (r_cnt == '0);

   always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
      if (!i_urx_rst_n) begin
         r_sync  <= 2'b11;
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_sr    <= '0;
      end else begin
         r_sync  <= {r_sync[0], i_urx_rx};
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_sr    <= w_sr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_sr_nxt    = r_sr;
      w_push      = 1'b0;
      w_ferr      = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_rx_s) begin
               w_state_nxt = START;
               w_cnt_nxt   = CNT_HALF;
            end
         end
         START: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (w_rx_s) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = DATA;
               w_bit_nxt   = 3'd0;
               w_cnt_nxt   = CNT_FULL;
            end
         end
         DATA: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_sr_nxt  = {w_rx_s, r_sr[7:1]};
               w_cnt_nxt = CNT_FULL;
               if (r_bit == 3'd7) w_state_nxt = STOP;
               else               w_bit_nxt   = r_bit + 1'b1;
            end
         end
         STOP: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (w_rx_s) begin
               w_push      = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_ferr      = 1'b1;
               w_state_nxt = BREAK;
            end
         end
         BREAK: begin
            if (w_rx_s) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef IDLI_UART_RX_FIFO_EN
   logic w_empty;

   idli_uart_rx_fifo_m #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_gck   (i_urx_gck),
      .i_rst_n (i_urx_rst_n),
      .i_push  (w_push),
      .i_data  (r_sr),
      .i_pop   (w_pop),
      .o_data  (o_urx_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign o_urx_vld = ~w_empty;
   assign w_pop     = o_urx_vld & i_urx_rdy;
`else
   uart_byte_t r_data;
   logic       r_vld;

   assign w_full     = r_vld;
   assign w_pop      = r_vld & i_urx_rdy;
   assign o_urx_data = r_data;
   assign o_urx_vld  = r_vld;

   // A pop in the same cycle frees the register, so the new byte is taken.
   always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
      if (!i_urx_rst_n) begin
         r_data <= '0;
         r_vld  <= 1'b0;
      end else if (w_push && (!r_vld || w_pop)) begin
         r_data <= r_sr;
         r_vld  <= 1'b1;
      end else if (w_pop) begin
         r_vld  <= 1'b0;
      end
   end
`endif

   always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
      if (!i_urx_rst_n) begin
         r_ferr <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_ferr <= w_ferr;
         r_ovf  <= w_push & w_full & ~w_pop;
      end
   end

   assign o_urx_frame_err = r_ferr;
   assign o_urx_overflow  = r_ovf;

endmodule
